// File: rtl/counter_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_array_ctrl
// Description : Read-modify-write engine for the 1W1R counter_array SRAM
//               (write port 0, read port 1). Services one counter op per
//               cycle with same-address bypass, clears the array after reset
//               and performs halving (aging) sweeps on request.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_array_ctrl #(
    parameter int unsigned DATA_WIDTH    = 3,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  age_start,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_old,
    output logic [DATA_WIDTH-1:0] rsp_new,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    // Internal op encoding: the two-bit request ops plus the aging op.
    localparam logic [2:0] c_OP_INC   = 3'd0;
    localparam logic [2:0] c_OP_DEC   = 3'd1;
    localparam logic [2:0] c_OP_CLR   = 3'd2;
    localparam logic [2:0] c_OP_SET   = 3'd3;
    localparam logic [2:0] c_OP_HALVE = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_DATA_MAX = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_DATA_MIN = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_AGE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_ptr;

    logic                  w_accept;
    logic                  w_age_issue;
    logic                  w_csb1;
    logic [ADDR_WIDTH-1:0] w_addr1;

    // Execute stage: op whose read was issued on the previous edge
    logic                  r_e_valid;
    logic                  r_e_rsp;
    logic [ADDR_WIDTH-1:0] r_e_addr;
    logic [2:0]            r_e_op;
    logic [DATA_WIDTH-1:0] r_e_data;

    // Write port registers and a copy of the write one cycle older
    logic                  r_csb0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_p_valid;
    logic [ADDR_WIDTH-1:0] r_p_addr;
    logic [DATA_WIDTH-1:0] r_p_data;

    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_new;

    logic                  r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DATA_WIDTH-1:0] r_rsp_old;
    logic [DATA_WIDTH-1:0] r_rsp_new;

    // State register; reset lands in the clear sweep or straight in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_ON_RESET) r_state <= S_INIT;
            else               r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus read-port issue (request in IDLE, sweep pointer in AGE)
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_age_issue  = 1'b0;
        w_addr1      = req_addr;
        case (r_state)
            S_INIT: begin
                if (r_ptr == c_PTR_LAST) w_state_next = S_IDLE;
            end
            S_IDLE: begin
                // rst_n gate keeps the read port quiet during reset when
                // the block resets directly into IDLE
                w_accept = req_valid & rst_n;
                if (age_start) w_state_next = S_AGE;
            end
            S_AGE: begin
                w_age_issue = 1'b1;
                w_addr1     = r_ptr;
                if (r_ptr == c_PTR_LAST) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_csb1 = ~(w_accept | w_age_issue);
    end

    // Sweep pointer advances every INIT/AGE cycle and wraps back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state == S_INIT || r_state == S_AGE) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Old value: newest in-flight write to the same address wins over the array
    always_comb begin
        w_old = dout1;
        if (!r_csb0 && (r_addr0 == r_e_addr)) begin
            w_old = r_din0;
        end else if (r_p_valid && (r_p_addr == r_e_addr)) begin
            w_old = r_p_data;
        end
        w_new = w_old;
        case (r_e_op)
            c_OP_INC:   w_new = (w_old == c_DATA_MAX) ? w_old : w_old + 1'b1;
            c_OP_DEC:   w_new = (w_old == c_DATA_MIN) ? w_old : w_old - 1'b1;
            c_OP_CLR:   w_new = c_DATA_MIN;
            c_OP_SET:   w_new = r_e_data;
            c_OP_HALVE: w_new = w_old >> 1;
            default:    w_new = w_old;
        endcase
    end

    // Execute-stage capture of the op whose read is issued this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid <= 1'b0;
            r_e_rsp   <= 1'b0;
            r_e_addr  <= '0;
            r_e_op    <= c_OP_INC;
            r_e_data  <= '0;
        end else begin
            r_e_valid <= w_accept | w_age_issue;
            r_e_rsp   <= w_accept;
            r_e_addr  <= w_addr1;
            r_e_op    <= w_accept ? {1'b0, req_op} : c_OP_HALVE;
            r_e_data  <= req_data;
        end
    end

    // Write port: zero fill during INIT, otherwise the executed op's result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csb0  <= 1'b1;
            r_addr0 <= '0;
            r_din0  <= '0;
        end else if (r_state == S_INIT) begin
            r_csb0  <= 1'b0;
            r_addr0 <= r_ptr;
            r_din0  <= '0;
        end else if (r_e_valid) begin
            r_csb0  <= 1'b0;
            r_addr0 <= r_e_addr;
            r_din0  <= w_new;
        end else begin
            r_csb0  <= 1'b1;
        end
    end

    // Previous write, still racing the array read issued on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid <= 1'b0;
            r_p_addr  <= '0;
            r_p_data  <= '0;
        end else begin
            r_p_valid <= ~r_csb0;
            r_p_addr  <= r_addr0;
            r_p_data  <= r_din0;
        end
    end

    // Response for requests only; aging ops complete silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_old   <= '0;
            r_rsp_new   <= '0;
        end else begin
            r_rsp_valid <= r_e_valid & r_e_rsp;
            if (r_e_valid && r_e_rsp) begin
                r_rsp_addr <= r_e_addr;
                r_rsp_old  <= w_old;
                r_rsp_new  <= w_new;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_old   = r_rsp_old;
    assign rsp_new   = r_rsp_new;
    assign csb0      = r_csb0;
    assign addr0     = r_addr0;
    assign din0      = r_din0;
    assign csb1      = w_csb1;
    assign addr1     = w_addr1;

endmodule
`default_nettype wire

// File: tb/tb_counter_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_array_ctrl
// Description : Directed and random bench for counter_array_ctrl with a
//               behavioural 1W1R SRAM and a scoreboard of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_array_ctrl;

    localparam int DW   = 3;
    localparam int AW   = 8;
    localparam int N    = 1 << AW;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          age_start;
    logic          busy;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_old;
    logic [DW-1:0] rsp_new;
    logic          csb0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] o;
        logic [DW-1:0] n;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] mem [N];
    logic          prefill;
    int            checks   = 0;
    int            failures = 0;

    counter_array_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_addr (req_addr),
        .req_data (req_data),
        .age_start(age_start),
        .busy     (busy),
        .rsp_valid(rsp_valid),
        .rsp_addr (rsp_addr),
        .rsp_old  (rsp_old),
        .rsp_new  (rsp_new),
        .csb0     (csb0),
        .addr0    (addr0),
        .din0     (din0),
        .csb1     (csb1),
        .addr1    (addr1),
        .dout1    (dout1)
    );

    always #5 clk = ~clk;

    // SRAM model: read returns the pre-write contents on a same-edge collision
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < N; i++) mem[i] <= DW'(5);
        end else if (!csb0) begin
            mem[addr0] <= din0;
        end
        if (!csb1) dout1 <= mem[addr1];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_f(input logic [1:0] op, input logic [DW-1:0] o,
                                            input logic [DW-1:0] d);
        int v;
        v = int'(o);
        case (op)
            2'd0:    v = (v >= MAXV) ? MAXV : v + 1;
            2'd1:    v = (v <= 0) ? 0 : v - 1;
            2'd2:    v = 0;
            default: v = int'(d);
        endcase
        return DW'(v);
    endfunction

    // One clock; responses are checked against the scoreboard after the edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_addr_old_new", 32'({rsp_addr, rsp_old, rsp_new}), 32'(e));
            end
        end
        chk("rsp_latency", 32'(sb_q.size() > 1), 32'd0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.a        = a;
        e.o        = ref_mem[a];
        e.n        = ref_f(op, e.o, d);
        ref_mem[a] = e.n;
        sb_q.push_back(e);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = a;
        req_data   = d;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic ref_halve();
        for (int i = 0; i < N; i++) ref_mem[i] = ref_mem[i] >> 1;
    endtask

    task automatic drain();
        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic cmp_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    // Follow the post-reset clear sweep: length, write order and data
    task automatic run_init(input string tag);
        int n   = 0;
        int wr  = 0;
        int bad = 0;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            if (csb0 === 1'b0) begin
                if (addr0 !== wr[AW-1:0] || din0 !== '0) bad++;
                wr++;
            end
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(N));
        chk({tag, "_write_count"}, 32'(wr), 32'(N));
        chk({tag, "_write_order"}, 32'(bad), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
    endtask

    initial begin
        int rd;
        int bad;
        int n;
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        rst_n     = 1'b0;
        prefill   = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_data  = '0;
        age_start = 1'b0;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        prefill = 1'b0;

        // Reset state
        chk("rst_csb0", 32'(csb0), 32'd1);
        chk("rst_csb1", 32'(csb1), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_addr0_din0", 32'({addr0, din0}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Post-reset clear sweep
        rst_n = 1'b1;
        run_init("init");
        repeat (2) tick();
        cmp_mem("init_array_clear");

        // Back-to-back increments on one address, saturating at the top
        repeat (9) do_op(2'd0, AW'(5), '0);
        drain();
        chk("inc_sat_array5", 32'(mem[5]), 32'd7);

        // SET then DEC next cycle: DEC must see the bypassed value
        do_op(2'd3, AW'(9), DW'(6));
        do_op(2'd1, AW'(9), '0);
        drain();
        chk("set_dec_array9", 32'(mem[9]), 32'd5);

        // Aging sweep, started together with a request that must still be taken
        do_op(2'd3, AW'(3), DW'(7));
        age_start = 1'b1;
        do_op(2'd3, AW'(4), DW'(5));
        age_start = 1'b0;
        ref_halve();
        rd  = 0;
        bad = 0;
        n   = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (csb1 === 1'b0) begin
                if (addr1 !== rd[AW-1:0]) bad++;
                rd++;
            end
            tick();
            n++;
        end
        chk("age_read_count", 32'(rd), 32'(N));
        chk("age_read_order", 32'(bad), 32'd0);
        drain();
        chk("age_array3", 32'(mem[3]), 32'd3);
        chk("age_array4", 32'(mem[4]), 32'd2);
        cmp_mem("age_array_all");

        // Reset in the middle of an aging sweep
        age_start = 1'b1;
        tick();
        age_start = 1'b0;
        n = 0;
        while (!(csb1 === 1'b0 && addr1 === AW'(100)) && n < 400) begin
            tick();
            n++;
        end
        chk("age_reach_ptr100", 32'(addr1), 32'd100);
        rst_n = 1'b0;
        #1;
        chk("midage_rst_csb0", 32'(csb0), 32'd1);
        chk("midage_rst_csb1", 32'(csb1), 32'd1);
        chk("midage_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midage_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_init("reinit");
        drain();
        cmp_mem("reinit_array_clear");

        // Random ops on a small address window to provoke hazards
        for (int c = 0; c < 10000; c++) begin
            if (req_ready === 1'b1 && $urandom_range(0, 3) != 0) begin
                op = 2'($urandom_range(0, 3));
                a  = AW'($urandom_range(0, 7));
                d  = DW'($urandom_range(0, MAXV));
                if ($urandom_range(0, 999) == 0) begin
                    age_start = 1'b1;
                    do_op(op, a, d);
                    age_start = 1'b0;
                    ref_halve();
                end else begin
                    do_op(op, a, d);
                end
            end else begin
                tick();
            end
        end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        drain();
        cmp_mem("random_array");
        chk("idle_csb0", 32'(csb0), 32'd1);
        chk("idle_csb1", 32'(csb1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
